round_referee: RTL and testbench

- Front-end arbiter for the reaction game; drives the scorer's round inputs (winrnd, right, tie).
- Watches the left and right player push-buttons and decides who pressed first, or whether the presses tied.
- Issues a single-cycle round-result strobe, then locks out further decisions until a hold-off expires and both buttons are released.
- leds_on is not touched by this block; it goes straight from the light sequencer to the scorer.

---
 rtl/round_referee.sv | 135 +++++++++++++
 tb/tb_round_referee.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/round_referee.sv
// Reaction-game referee: decides first press or tie, strobes winrnd, then locks out.
// Optional ROUND_REFEREE_SYNC_EN adds a two-flop synchronizer on both buttons.
module round_referee #(
  parameter int unsigned LOCKOUT_CYCLES = 4,
  parameter int unsigned LOCK_W         = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pbl,
  input  logic       pbr,
  output logic       winrnd,
  output logic       right,
  output logic       tie,
  output logic [7:0] rounds
);

  typedef enum logic [1:0] {
    RELEASE = 2'd0,
    ARMED   = 2'd1,
    LOCKOUT = 2'd2
  } state_t;

  localparam logic [LOCK_W-1:0] LOCK_LOAD =
    LOCK_W'((LOCKOUT_CYCLES == 0) ? 0 : LOCKOUT_CYCLES - 1);

  logic btn_l;
  logic btn_r;

`ifdef ROUND_REFEREE_SYNC_EN
  logic [1:0] sync_l_q;
  logic [1:0] sync_r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_l_q <= '0;
      sync_r_q <= '0;
    end else begin
      sync_l_q <= {sync_l_q[0], pbl};
      sync_r_q <= {sync_r_q[0], pbr};
    end
  end

  assign btn_l = sync_l_q[1];
  assign btn_r = sync_r_q[1];
`else
  assign btn_l = pbl;
  assign btn_r = pbr;
`endif

  state_t            state_q, state_d;
  logic [LOCK_W-1:0] cnt_q, cnt_d;
  logic              prev_l_q, prev_l_d;
  logic              prev_r_q, prev_r_d;
  logic              winrnd_q, winrnd_d;
  logic              right_q, right_d;
  logic              tie_q, tie_d;
  logic [7:0]        rounds_q, rounds_d;

  logic press_l;
  logic press_r;

  assign press_l = btn_l & ~prev_l_q;
  assign press_r = btn_r & ~prev_r_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    prev_l_d = btn_l;
    prev_r_d = btn_r;
    winrnd_d = 1'b0;
    right_d  = right_q;
    tie_d    = tie_q;
    rounds_d = rounds_q;
    case (state_q)
      ARMED: begin
        if (press_l | press_r) begin
          winrnd_d = 1'b1;
          right_d  = press_r & ~press_l;
          tie_d    = press_l & press_r;
          rounds_d = rounds_q + 8'd1;
          if (LOCKOUT_CYCLES == 0) begin
            state_d = RELEASE;
          end else begin
            state_d = LOCKOUT;
            cnt_d   = LOCK_LOAD;
          end
        end
      end
      LOCKOUT: begin
        if (cnt_q == '0) begin
          state_d = RELEASE;
        end else begin
          cnt_d = cnt_q - LOCK_W'(1);
        end
      end
      RELEASE: begin
        // Re-arm only once both players have let go.
        if (!btn_l && !btn_r) begin
          state_d = ARMED;
        end
      end
      default: begin
        state_d = RELEASE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= RELEASE;
      cnt_q    <= '0;
      prev_l_q <= 1'b0;
      prev_r_q <= 1'b0;
      winrnd_q <= 1'b0;
      right_q  <= 1'b0;
      tie_q    <= 1'b0;
      rounds_q <= 8'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      prev_l_q <= prev_l_d;
      prev_r_q <= prev_r_d;
      winrnd_q <= winrnd_d;
      right_q  <= right_d;
      tie_q    <= tie_d;
      rounds_q <= rounds_d;
    end
  end

  assign winrnd = winrnd_q;
  assign right  = right_q;
  assign tie    = tie_q;
  assign rounds = rounds_q;

endmodule

// File: tb/tb_round_referee.sv
// Bench for round_referee: expected strobes queued at stimulus time,
// popped and compared when winrnd rises.
module tb_round_referee;

  logic       clk = 1'b0;
  logic       rst;
  logic       pbl;
  logic       pbr;
  logic       winrnd;
  logic       right;
  logic       tie;
  logic [7:0] rounds;

  round_referee dut (
    .clk    (clk),
    .rst    (rst),
    .pbl    (pbl),
    .pbr    (pbr),
    .winrnd (winrnd),
    .right  (right),
    .tie    (tie),
    .rounds (rounds)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       r;
    logic       t;
    logic [7:0] n;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         nstrobe = 0;
  logic [7:0] exp_rounds = 8'd0;
  logic       last_win = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      last_win = 1'b0;
    end else begin
      if (winrnd) begin
        nstrobe++;
        checks++;
        if (last_win) begin
          errors++;
          $display("FAIL strobe_width winrnd=1 on consecutive cycles, required single cycle");
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_strobe winrnd=1 rounds=%0d, required no strobe", rounds);
        end else begin
          e = exp_q.pop_front();
          if ({right, tie, rounds} !== {e.r, e.t, e.n}) begin
            errors++;
            $display("FAIL strobe_result got right=%b tie=%b rounds=%0d, required right=%b tie=%b rounds=%0d",
                     right, tie, rounds, e.r, e.t, e.n);
          end
        end
      end
      last_win = winrnd;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic void expect_strobe(input logic r, input logic t);
    exp_t e;
    exp_rounds = exp_rounds + 8'd1;
    e.r = r;
    e.t = t;
    e.n = exp_rounds;
    exp_q.push_back(e);
  endfunction

  task automatic settle();
    pbl = 1'b0;
    pbr = 1'b0;
    repeat (7) step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    pbl = 1'b0;
    pbr = 1'b0;
    repeat (2) step();
    checks++;
    if ({winrnd, right, tie, rounds} !== 11'd0) begin
      errors++;
      $display("FAIL reset_outputs got winrnd=%b right=%b tie=%b rounds=%0d, required all 0",
               winrnd, right, tie, rounds);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_left();
    expect_strobe(1'b0, 1'b0);
    pbl = 1'b1;
    step();
    checks++;
    if (winrnd !== 1'b1 || rounds !== exp_rounds) begin
      errors++;
      $display("FAIL left_strobe got winrnd=%b rounds=%0d, required 1 and %0d",
               winrnd, rounds, exp_rounds);
    end
    step();
    checks++;
    if (winrnd !== 1'b0) begin
      errors++;
      $display("FAIL left_width got winrnd=%b, required 0", winrnd);
    end
    repeat (3) step();
    checks++;
    if (right !== 1'b0 || tie !== 1'b0) begin
      errors++;
      $display("FAIL left_hold got right=%b tie=%b, required 0 0", right, tie);
    end
    settle();
  endtask

  task automatic test_right_then_left();
    int s;
    s = nstrobe;
    expect_strobe(1'b1, 1'b0);
    pbr = 1'b1;
    step();
    pbl = 1'b1;
    repeat (4) step();
    checks++;
    if (nstrobe - s !== 1) begin
      errors++;
      $display("FAIL right_first_count got %0d strobes, required 1", nstrobe - s);
    end
    checks++;
    if (right !== 1'b1 || tie !== 1'b0 || rounds !== exp_rounds) begin
      errors++;
      $display("FAIL right_first_hold got right=%b tie=%b rounds=%0d, required 1 0 %0d",
               right, tie, rounds, exp_rounds);
    end
    settle();
  endtask

  task automatic test_tie();
    expect_strobe(1'b0, 1'b1);
    pbl = 1'b1;
    pbr = 1'b1;
    step();
    checks++;
    if (winrnd !== 1'b1 || tie !== 1'b1 || right !== 1'b0) begin
      errors++;
      $display("FAIL tie_strobe got winrnd=%b tie=%b right=%b, required 1 1 0",
               winrnd, tie, right);
    end
    settle();
  endtask

  task automatic test_lockout_gating();
    int s;
    s = nstrobe;
    expect_strobe(1'b0, 1'b0);
    pbl = 1'b1;
    step();
    for (int i = 1; i < 10; i++) begin
      pbr = (i == 3 || i == 7);
      step();
    end
    checks++;
    if (nstrobe - s !== 1) begin
      errors++;
      $display("FAIL gating_count got %0d strobes, required 1", nstrobe - s);
    end
    pbl = 1'b0;
    pbr = 1'b0;
    step();
    expect_strobe(1'b0, 1'b0);
    pbl = 1'b1;
    step();
    checks++;
    if (winrnd !== 1'b1 || rounds !== exp_rounds) begin
      errors++;
      $display("FAIL gating_rearm got winrnd=%b rounds=%0d, required 1 %0d",
               winrnd, rounds, exp_rounds);
    end
    settle();
  endtask

  task automatic test_lockout_length();
    expect_strobe(1'b0, 1'b0);
    pbl = 1'b1;
    step();
    pbl = 1'b0;
    repeat (5) step();
    expect_strobe(1'b0, 1'b0);
    pbl = 1'b1;
    step();
    checks++;
    if (winrnd !== 1'b1) begin
      errors++;
      $display("FAIL lockout_earliest got winrnd=%b, required 1", winrnd);
    end
    pbl = 1'b0;
    repeat (4) step();
    pbl = 1'b1;
    step();
    checks++;
    if (winrnd !== 1'b0) begin
      errors++;
      $display("FAIL lockout_too_early got winrnd=%b, required 0", winrnd);
    end
    pbl = 1'b0;
    step();
    expect_strobe(1'b0, 1'b0);
    pbl = 1'b1;
    step();
    checks++;
    if (winrnd !== 1'b1) begin
      errors++;
      $display("FAIL lockout_rearm got winrnd=%b, required 1", winrnd);
    end
    settle();
  endtask

  task automatic test_reset_held();
    int s;
    pbl = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (winrnd !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_strobe got winrnd=%b, required 1", winrnd);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (winrnd !== 1'b0 || rounds !== 8'd0) begin
      errors++;
      $display("FAIL async_reset got winrnd=%b rounds=%0d, required 0 0", winrnd, rounds);
    end
    exp_rounds = 8'd0;
    repeat (2) step();
    rst = 1'b0;
    s = nstrobe;
    repeat (5) step();
    checks++;
    if (nstrobe !== s) begin
      errors++;
      $display("FAIL held_through_reset got %0d strobes, required 0", nstrobe - s);
    end
    pbl = 1'b0;
    step();
    expect_strobe(1'b0, 1'b0);
    pbl = 1'b1;
    step();
    checks++;
    if (winrnd !== 1'b1 || rounds !== 8'd1) begin
      errors++;
      $display("FAIL post_reset_press got winrnd=%b rounds=%0d, required 1 1", winrnd, rounds);
    end
    settle();
  endtask

  task automatic test_wrap();
    rst = 1'b1;
    pbl = 1'b0;
    pbr = 1'b0;
    step();
    rst = 1'b0;
    exp_rounds = 8'd0;
    step();
    for (int i = 0; i < 256; i++) begin
      expect_strobe(i[0], 1'b0);
      pbl = ~i[0];
      pbr = i[0];
      step();
      if (i == 254) begin
        checks++;
        if (rounds !== 8'd255) begin
          errors++;
          $display("FAIL wrap_255 got rounds=%0d, required 255", rounds);
        end
      end
      pbl = 1'b0;
      pbr = 1'b0;
      repeat (5) step();
    end
    checks++;
    if (rounds !== 8'd0) begin
      errors++;
      $display("FAIL wrap_zero got rounds=%0d, required 0", rounds);
    end
    settle();
  endtask

  initial begin
    rst = 1'b1;
    pbl = 1'b0;
    pbr = 1'b0;
    test_reset();
    test_left();
    test_right_then_left();
    test_tie();
    test_lockout_gating();
    test_lockout_length();
    test_reset_held();
    test_wrap();
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL pending_strobes got %0d left in queue, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
